// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter using shift-add-3 (double dabble).
// Converts one input bit per clock and reports the packed BCD result with a one-cycle
// done pulse. It also flags values that need more than DIGITS decimal digits.
module bin2bcd_serial #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      binary_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int ACC_W = 4 * DIGITS;
    // The counter only needs to reach BIN_W-1. It is kept at least 1 bit wide for BIN_W=1.
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [BIN_W-1:0]       shreg_q;
    logic [BIN_W-1:0]       shreg_d;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W-1:0]       acc_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   ready_q;
    logic                   done_q;
    logic [ACC_W-1:0]       bcd_q;
    logic                   overflow_q;

    // Digit correction: a digit of 5..9 becomes 8..12.
    // After the next doubling, the digit then carries correctly into the next decade.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // The correction is applied to every digit independently. No carry crosses a digit boundary.
    function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = add3_digit(a[4*k +: 4]);
        end
        return r;
    endfunction

    // One double-dabble step: correct the digits, then shift {acc, shreg} left by one bit.
    // A 1 that leaves the top digit means the value needs more than DIGITS digits.
    always_comb begin
        acc_adj          = add3_all(acc_q);
        {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
        ovf_d            = ovf_q | acc_adj[ACC_W-1];
        cnt_d            = cnt_q + 1'b1;
    end

    // Control FSM with registered handshake outputs and the result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        shreg_q <= binary_i;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_d;
                    ovf_q   <= ovf_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q      <= acc_q;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial.
// Uses a 20-bit/7-digit instance and a 10-bit/3-digit instance on a shared clock.
module tb_bin2bcd_serial;

    logic        clk;
    logic        rst_w, w_start, w_ready, w_done, w_ovf;
    logic [19:0] w_bin;
    logic [27:0] w_bcd;
    logic        rst_n, n_start, n_ready, n_done, n_ovf;
    logic [9:0]  n_bin;
    logic [11:0] n_bcd;

    int tests_run = 0;
    int fails     = 0;

    bin2bcd_serial #(.BIN_W(20), .DIGITS(7)) dut_w (
        .clk_i(clk), .reset_i(rst_w), .start_i(w_start), .binary_i(w_bin),
        .ready_o(w_ready), .done_o(w_done), .bcd_o(w_bcd), .overflow_o(w_ovf));

    bin2bcd_serial #(.BIN_W(10), .DIGITS(3)) dut_n (
        .clk_i(clk), .reset_i(rst_n), .start_i(n_start), .binary_i(n_bin),
        .ready_o(n_ready), .done_o(n_done), .bcd_o(n_bcd), .overflow_o(n_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] ref7(input int unsigned v);
        logic [27:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 7; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] ref3(input int unsigned v);
        logic [11:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one conversion on the wide instance.
    // Returns in the done cycle, with latency counted in edges from the accepting edge.
    task automatic conv_w(input logic [19:0] v, output logic [27:0] b, output logic o,
                          output int lat, output logic busy_bad, output logic hold_bad);
        int g;
        logic [27:0] b0;
        logic o0;
        busy_bad = 1'b0; hold_bad = 1'b0; lat = -1; b = '0; o = 1'b0;
        g = 0;
        while (w_ready !== 1'b1 && g < 50) begin tick(); g++; end
        if (w_ready !== 1'b1) return;
        b0 = w_bcd; o0 = w_ovf;
        w_bin = v; w_start = 1'b1;
        tick();
        w_start = 1'b0; w_bin = 20'($urandom);
        lat = 0;
        while (w_done !== 1'b1 && lat < 60) begin
            if (w_ready !== 1'b0) busy_bad = 1'b1;
            if (w_bcd !== b0 || w_ovf !== o0) hold_bad = 1'b1;
            tick();
            lat++;
        end
        if (w_ready !== 1'b1) busy_bad = 1'b1;
        b = w_bcd; o = w_ovf;
    endtask

    task automatic conv_n(input logic [9:0] v, output logic [11:0] b, output logic o,
                          output int lat, output logic busy_bad);
        int g;
        busy_bad = 1'b0; lat = -1; b = '0; o = 1'b0;
        g = 0;
        while (n_ready !== 1'b1 && g < 50) begin tick(); g++; end
        if (n_ready !== 1'b1) return;
        n_bin = v; n_start = 1'b1;
        tick();
        n_start = 1'b0; n_bin = 10'($urandom);
        lat = 0;
        while (n_done !== 1'b1 && lat < 40) begin
            if (n_ready !== 1'b0) busy_bad = 1'b1;
            tick();
            lat++;
        end
        if (n_ready !== 1'b1) busy_bad = 1'b1;
        b = n_bcd; o = n_ovf;
    endtask

    task automatic test_reset();
        rst_w = 1'b1; rst_n = 1'b1;
        w_start = 1'b1; n_start = 1'b1;
        w_bin = 20'd77; n_bin = 10'd77;
        repeat (3) tick();
        tests_run++;
        if ({w_ready, w_done, w_ovf, w_bcd} !== {1'b1, 1'b0, 1'b0, 28'h0}) begin
            fails++;
            $display("FAIL reset_wide: ready=%b done=%b ovf=%b bcd=%h, want 1 0 0 0000000",
                     w_ready, w_done, w_ovf, w_bcd);
        end
        tests_run++;
        if ({n_ready, n_done, n_ovf, n_bcd} !== {1'b1, 1'b0, 1'b0, 12'h0}) begin
            fails++;
            $display("FAIL reset_narrow: ready=%b done=%b ovf=%b bcd=%h, want 1 0 0 000",
                     n_ready, n_done, n_ovf, n_bcd);
        end
        w_start = 1'b0; n_start = 1'b0;
        rst_w = 1'b0; rst_n = 1'b0;
        tick();
        tests_run++;
        if (w_ready !== 1'b1 || w_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_ignored: ready=%b done=%b, want 1 0", w_ready, w_done);
        end
    endtask

    task automatic test_zero();
        logic [27:0] b; logic o, bb, hb; int lat;
        conv_w(20'd0, b, o, lat, bb, hb);
        tests_run++;
        if (lat != 21) begin
            fails++;
            $display("FAIL zero_latency: got %0d edges, want 21", lat);
        end
        tests_run++;
        if ({o, b} !== {1'b0, 28'h0000000}) begin
            fails++;
            $display("FAIL zero_value: bcd=%h ovf=%b, want 0000000 0", b, o);
        end
        tests_run++;
        if (bb !== 1'b0) begin
            fails++;
            $display("FAIL zero_ready_timing: busy flag=%b, want 0", bb);
        end
        tick();
        tests_run++;
        if (w_done !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_width: done=%b one cycle later, want 0", w_done);
        end
    endtask

    task automatic test_wide_values();
        logic [19:0] vals [4] = '{20'd1048575, 20'd999999, 20'd1, 20'd500009};
        logic [27:0] exps [4] = '{28'h1048575, 28'h0999999, 28'h0000001, 28'h0500009};
        logic [27:0] b; logic o, bb, hb; int lat;
        for (int i = 0; i < 4; i++) begin
            conv_w(vals[i], b, o, lat, bb, hb);
            tests_run++;
            if ({o, b} !== {1'b0, exps[i]} || lat != 21) begin
                fails++;
                $display("FAIL wide_value_%0d: bcd=%h ovf=%b lat=%0d, want %h 0 21",
                         vals[i], b, o, lat, exps[i]);
            end
            tests_run++;
            if (bb !== 1'b0 || hb !== 1'b0) begin
                fails++;
                $display("FAIL wide_hold_%0d: busy flag=%b hold flag=%b, want 0 0",
                         vals[i], bb, hb);
            end
        end
    endtask

    task automatic test_ignore_busy_start();
        int cyc; logic bad;
        w_bin = 20'd4321; w_start = 1'b1;
        tick();
        w_start = 1'b0;
        repeat (4) tick();
        w_start = 1'b1; w_bin = 20'd999;
        tick();
        w_start = 1'b0;
        cyc = 5;
        while (w_done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
        tests_run++;
        if (cyc != 21 || w_bcd !== 28'h0004321) begin
            fails++;
            $display("FAIL busy_start_ignored: lat=%0d bcd=%h, want 21 0004321", cyc, w_bcd);
        end
        bad = 1'b0;
        repeat (25) begin
            tick();
            if (w_done !== 1'b0 || w_ready !== 1'b1) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_not_queued: spurious activity flag=%b, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, nd;
        int t [2];
        logic [27:0] b [2];
        t[0] = -1; t[1] = -1; b[0] = '0; b[1] = '0;
        nd = 0;
        w_bin = 20'd12345; w_start = 1'b1;
        tick();
        w_bin = 20'd67890;
        cyc = 0;
        while (nd < 2 && cyc < 80) begin
            tick();
            cyc++;
            if (w_done === 1'b1) begin
                t[nd] = cyc; b[nd] = w_bcd; nd++;
                if (nd == 2) w_start = 1'b0;
            end
        end
        w_start = 1'b0;
        tests_run++;
        if (nd != 2 || t[0] != 21 || (t[1] - t[0]) != 22) begin
            fails++;
            $display("FAIL b2b_timing: pulses=%0d first=%0d spacing=%0d, want 2 21 22",
                     nd, t[0], t[1] - t[0]);
        end
        tests_run++;
        if (b[0] !== 28'h0012345 || b[1] !== 28'h0067890) begin
            fails++;
            $display("FAIL b2b_values: bcd=%h,%h, want 0012345,0067890", b[0], b[1]);
        end
        tick();
        tests_run++;
        if (w_done !== 1'b0 || w_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stop: done=%b ready=%b, want 0 1", w_done, w_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] b; logic o, bb, hb, bad; int lat;
        w_bin = 20'd54321; w_start = 1'b1;
        tick();
        w_start = 1'b0;
        repeat (9) tick();
        rst_w = 1'b1;
        tick();
        rst_w = 1'b0;
        tests_run++;
        if ({w_ready, w_done, w_ovf, w_bcd} !== {1'b1, 1'b0, 1'b0, 28'h0}) begin
            fails++;
            $display("FAIL reset_mid_state: ready=%b done=%b ovf=%b bcd=%h, want 1 0 0 0000000",
                     w_ready, w_done, w_ovf, w_bcd);
        end
        bad = 1'b0;
        repeat (30) begin
            tick();
            if (w_done !== 1'b0 || w_bcd !== 28'h0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abandon: done/bcd activity flag=%b, want 0", bad);
        end
        conv_w(20'd54321, b, o, lat, bb, hb);
        tests_run++;
        if ({o, b} !== {1'b0, 28'h0054321} || lat != 21) begin
            fails++;
            $display("FAIL reset_mid_restart: bcd=%h ovf=%b lat=%0d, want 0054321 0 21", b, o, lat);
        end
    endtask

    task automatic test_small_boundaries();
        logic [9:0]  vals [3] = '{10'd999, 10'd1000, 10'd1023};
        logic [11:0] exps [3] = '{12'h999, 12'h000, 12'h023};
        logic        ovfs [3] = '{1'b0, 1'b1, 1'b1};
        logic [11:0] b; logic o, bb; int lat;
        for (int i = 0; i < 3; i++) begin
            conv_n(vals[i], b, o, lat, bb);
            tests_run++;
            if ({o, b} !== {ovfs[i], exps[i]} || lat != 11 || bb !== 1'b0) begin
                fails++;
                $display("FAIL small_%0d: bcd=%h ovf=%b lat=%0d busy=%b, want %h %b 11 0",
                         vals[i], b, o, lat, bb, exps[i], ovfs[i]);
            end
        end
    endtask

    task automatic test_small_exhaustive();
        logic [11:0] b; logic o, bb; int lat;
        for (int v = 0; v < 1024; v++) begin
            conv_n(10'(v), b, o, lat, bb);
            tests_run++;
            if ({o, b} !== {(v >= 1000), ref3(v)} || lat != 11 || bb !== 1'b0) begin
                fails++;
                $display("FAIL small_sweep_%0d: bcd=%h ovf=%b lat=%0d busy=%b, want %h %b 11 0",
                         v, b, o, lat, bb, ref3(v), (v >= 1000));
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [27:0] b; logic o, bb, hb; int lat;
        int unsigned v;
        for (int i = 0; i < 1000; i++) begin
            v = $urandom_range(0, 20'hFFFFF);
            conv_w(20'(v), b, o, lat, bb, hb);
            tick();
            tests_run++;
            if ({o, b} !== {1'b0, ref7(v)} || lat != 21 || bb !== 1'b0 || hb !== 1'b0
                || w_done !== 1'b0) begin
                fails++;
                $display("FAIL wide_sweep_%0d: bcd=%h ovf=%b lat=%0d busy=%b hold=%b done_after=%b, want %h 0 21 0 0 0",
                         v, b, o, lat, bb, hb, w_done, ref7(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_wide_values();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_small_boundaries();
        test_small_exhaustive();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
